// File: rtl/ucsbece154a_mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encodings,
// opcode/funct constants, ALU control encodings, mux-select encodings and a
// helper that tells whether an R-type funct is implemented.
package ucsbece154a_mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic funct_legal(input logic [5:0] funct);
    return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
           (funct == FN_OR)  || (funct == FN_SLT);
  endfunction

endpackage

// File: rtl/ucsbece154a_mc_controller_aludec.sv
// ALU decoder: maps the operation class and R-type funct to ALUControl.
//   aluop_i      in  2  00 add, 01 sub, 10 use funct
//   funct_i      in  6  instr[5:0]
//   alucontrol_o out 3  ALU operation select
module ucsbece154a_mc_controller_aludec
  import ucsbece154a_mc_controller_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    unique case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unsupported functs never reach EXEC, so add is a safe fallback
        case (funct_i)
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle MIPS control unit (shared instruction/data memory).
// Sequences each instruction through the FSM and drives datapath controls.
//   clk, reset (sync, active-low)
//   op_i, funct_i, zero_i              instruction fields and ALU zero flag
//   pcen_o, iord_o, memwrite_o, irwrite_o, regdst_o, memtoreg_o, regwrite_o,
//   alusrca_o, alusrcb_o, alucontrol_o, pcsrc_o   datapath controls
//   illegal_o                          pulses in DECODE on unsupported op/funct
module ucsbece154a_mc_controller
  import ucsbece154a_mc_controller_pkg::*;
#(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       pcen_o,
  output logic       iord_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       regdst_o,
  output logic       memtoreg_o,
  output logic       regwrite_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [2:0] alucontrol_o,
  output logic [1:0] pcsrc_o,
  output logic       illegal_o
);

  state_t     state_q, state_d, state_eff;
  logic       is_bne_q, is_bne_d;
  logic       pcwrite, branch;
  logic [1:0] aluop;
  logic       op_legal, decode_illegal;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_bne_q <= is_bne_d;
    end
  end

  always_comb begin
    case (op_i)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_legal = 1'b1;
      OP_BNE:  op_legal = ENABLE_BNE;
      default: op_legal = 1'b0;
    endcase
    decode_illegal = !op_legal || ((op_i == OP_RTYPE) && !funct_legal(funct_i));
  end

  // Next state; the branch sense is captured in DECODE so BRANCH need not re-read op
  always_comb begin
    state_d  = S_FETCH;
    is_bne_d = is_bne_q;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        is_bne_d = ENABLE_BNE && (op_i == OP_BNE);
        if (decode_illegal) state_d = S_FETCH;
        else begin
          case (op_i)
            OP_LW, OP_SW:   state_d = S_MEMADR;
            OP_RTYPE:       state_d = S_EXEC;
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
            OP_ADDI:        state_d = S_ADDIEX;
            OP_J:           state_d = S_JUMP;
            default:        state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode; while reset is low the outputs look like FETCH with all
  // state-changing enables suppressed
  always_comb begin
    state_eff  = reset ? state_q : S_FETCH;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord_o     = 1'b0;
    memwrite_o = 1'b0;
    irwrite_o  = 1'b0;
    regdst_o   = 1'b0;
    memtoreg_o = 1'b0;
    regwrite_o = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = SRCB_REG;
    aluop      = ALUOP_ADD;
    pcsrc_o    = PCSRC_ALU;
    illegal_o  = 1'b0;
    unique case (state_eff)
      S_FETCH: begin
        alusrcb_o = SRCB_FOUR;
        irwrite_o = reset;
        pcwrite   = reset;
      end
      S_DECODE: begin
        alusrcb_o = SRCB_IMMSH;
        illegal_o = decode_illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
      end
      S_MEMRD: iord_o = 1'b1;
      // Address stays on ALUOut through write-back so the memory read is undisturbed
      S_MEMWB: begin
        iord_o     = 1'b1;
        memtoreg_o = 1'b1;
        regwrite_o = 1'b1;
      end
      S_MEMWR: begin
        iord_o     = 1'b1;
        memwrite_o = 1'b1;
      end
      S_EXEC: begin
        alusrca_o = 1'b1;
        aluop     = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regdst_o   = 1'b1;
        regwrite_o = 1'b1;
      end
      S_BRANCH: begin
        alusrca_o = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_o   = PCSRC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIWB: regwrite_o = 1'b1;
      S_JUMP: begin
        pcsrc_o = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcen_o = pcwrite | (branch & (zero_i ^ is_bne_q));

  ucsbece154a_mc_controller_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct_i),
    .alucontrol_o (alucontrol_o)
  );

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
module tb_ucsbece154a_mc_controller;
  import ucsbece154a_mc_controller_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] op = 6'h00, funct = 6'h00;
  logic       zero = 1'b0;
  logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  int checks = 0;
  int failures = 0;
  logic [19:0] sb[$];

  always #5 clk = ~clk;

  ucsbece154a_mc_controller #(.ENABLE_BNE(1'b1)) dut (
    .clk(clk), .reset(reset), .op_i(op), .funct_i(funct), .zero_i(zero),
    .pcen_o(pcen), .iord_o(iord), .memwrite_o(memwrite), .irwrite_o(irwrite),
    .regdst_o(regdst), .memtoreg_o(memtoreg), .regwrite_o(regwrite),
    .alusrca_o(alusrca), .alusrcb_o(alusrcb), .alucontrol_o(alucontrol),
    .pcsrc_o(pcsrc), .illegal_o(illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,alu,pcsrc,illegal,state}
  function automatic logic [19:0] v(input logic [3:0] st, input logic pe, io, mw, irw, rd, m2r,
                                    rw, sa, input logic [1:0] sb_, input logic [2:0] alu,
                                    input logic [1:0] ps, input logic ill);
    return {pe, io, mw, irw, rd, m2r, rw, sa, sb_, alu, ps, ill, st};
  endfunction

  function automatic logic [19:0] rst_v(input logic [3:0] st);
    return v(st, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
  endfunction

  // Push the expected vector, compare it at the falling edge, advance one cycle
  task automatic step(input logic [19:0] e, input string tag);
    logic [19:0] got, want;
    sb.push_back(e);
    @(negedge clk);
    got  = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, alucontrol, pcsrc, illegal, 4'(dut.state_q)};
    want = sb.pop_front();
    chk(tag, 32'(got), 32'(want));
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH; exp_alu is the ALU op expected in EXEC
  task automatic instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input logic [2:0] exp_alu, input bit fn_ok, input string nm);
    op = o; funct = f; zero = z;
    step(v(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0), {nm, "_fetch"});
    case (o)
      6'h23: begin
        step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), {nm, "_decode"});
        step(v(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), {nm, "_memadr"});
        step(v(4'd3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0), {nm, "_memrd"});
        step(v(4'd4, 0, 1, 0, 0, 0, 1, 1, 0, 2'b00, 3'b010, 2'b00, 0), {nm, "_memwb"});
      end
      6'h2b: begin
        step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), {nm, "_decode"});
        step(v(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), {nm, "_memadr"});
        step(v(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 0), {nm, "_memwr"});
      end
      6'h00: begin
        if (fn_ok) begin
          step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), {nm, "_decode"});
          step(v(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, exp_alu, 2'b00, 0), {nm, "_exec"});
          step(v(4'd7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0), {nm, "_aluwb"});
        end else
          step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 1), {nm, "_decode"});
      end
      6'h04, 6'h05: begin
        step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), {nm, "_decode"});
        step(v(4'd8, (o == 6'h04) ? z : !z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0),
             {nm, "_branch"});
      end
      6'h08: begin
        step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), {nm, "_decode"});
        step(v(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), {nm, "_addiex"});
        step(v(4'd10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b010, 2'b00, 0), {nm, "_addiwb"});
      end
      6'h02: begin
        step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), {nm, "_decode"});
        step(v(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b10, 0), {nm, "_jump"});
      end
      default:
        step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 1), {nm, "_decode"});
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step(rst_v(4'd0), "reset_hold");
    reset = 1'b1;

    instr(6'h23, 6'h00, 0, 3'b010, 1, "lw");
    instr(6'h2b, 6'h00, 0, 3'b010, 1, "sw");
    instr(6'h00, 6'h20, 0, 3'b010, 1, "r_add");
    instr(6'h00, 6'h22, 0, 3'b110, 1, "r_sub");
    instr(6'h00, 6'h24, 0, 3'b000, 1, "r_and");
    instr(6'h00, 6'h25, 0, 3'b001, 1, "r_or");
    instr(6'h00, 6'h2a, 0, 3'b111, 1, "r_slt");
    instr(6'h00, 6'h3f, 0, 3'b010, 0, "r_badfn");
    instr(6'h08, 6'h00, 0, 3'b010, 1, "addi");
    instr(6'h04, 6'h00, 1, 3'b010, 1, "beq_t");
    instr(6'h04, 6'h00, 0, 3'b010, 1, "beq_nt");
    instr(6'h05, 6'h00, 1, 3'b010, 1, "bne_nt");
    instr(6'h05, 6'h00, 0, 3'b010, 1, "bne_t");
    instr(6'h02, 6'h00, 0, 3'b010, 1, "j");
    instr(6'h3f, 6'h00, 0, 3'b010, 1, "op3f");

    // Reset while a lw is in MEMRD: abandoned, then a clean fetch
    op = 6'h23; funct = 6'h00; zero = 1'b0;
    step(v(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0), "mid_fetch");
    step(v(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0), "mid_decode");
    step(v(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0), "mid_memadr");
    reset = 1'b0;
    step(rst_v(4'd3), "mid_rst_memrd");
    step(rst_v(4'd0), "mid_rst_fetch");
    reset = 1'b1;
    instr(6'h2b, 6'h00, 0, 3'b010, 1, "after_rst_sw");

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
